// File: rtl/operand_fetch_pkg.sv
// Shared constants and helpers for the ID-stage operand fetch and its scoreboard.
// The register-file constants are shared with the rest of the integer pipeline.
package operand_fetch_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int TAG_W      = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;
  localparam int STALL_W    = 32;

  localparam logic [XLEN-1:0] ZeroWord    = '0;
  localparam logic            RstEnable   = 1'b1;
  localparam logic            ReadEnable  = 1'b1;
  localparam logic            WriteEnable = 1'b1;

  typedef enum logic [1:0] {
    HAZ_NONE = 2'd0,
    HAZ_RAW  = 2'd1,
    HAZ_WAW  = 2'd2
  } haz_kind_e;

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (v == '1) ? v : v + STALL_W'(1);
  endfunction

endpackage

// File: rtl/of_scoreboard.sv
// Pending-destination scoreboard: one busy bit per register, x0 never busy.
// A new writer (set) beats a same-cycle flush kill or writeback clear.
module of_scoreboard
  import operand_fetch_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              kill_en,
  input  logic [ADDR_W-1:0] kill_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  output logic              busy_rs1,
  output logic              busy_rs2,
  output logic              busy_rd
);

  localparam int N = 1 << ADDR_W;

  logic [N-1:0] set_mask;
  logic [N-1:0] kill_mask;
  logic [N-1:0] clr_mask;
  logic [N-1:0] busy_q;
  logic [N-1:0] busy_d;

  always_comb begin
    set_mask  = set_en  ? (N'(1) << set_addr)  : '0;
    kill_mask = kill_en ? (N'(1) << kill_addr) : '0;
    clr_mask  = clr_en  ? (N'(1) << clr_addr)  : '0;
    // set is OR-ed in last so it overrides both kinds of clear; bit 0 is forced low
    busy_d    = ((busy_q & ~kill_mask & ~clr_mask) | set_mask) & ~N'(1);
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_rs1 = busy_q[rs1];
  assign busy_rs2 = busy_q[rs2];
  assign busy_rd  = busy_q[rd];

endmodule

// File: rtl/operand_fetch.sv
// ID-stage operand fetch: drives register-file reads, stalls on RAW/WAW hazards
// against pending writebacks, and registers operands into a one-entry stage toward EX.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int XLEN       = operand_fetch_pkg::XLEN,
  parameter int REG_ADDR_W = operand_fetch_pkg::REG_ADDR_W,
  parameter int TAG_W      = operand_fetch_pkg::TAG_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic                  in_rs1_en,
  input  logic                  in_rs2_en,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_rd_en,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  re1,
  output logic                  re2,
  output logic [REG_ADDR_W-1:0] raddr1,
  output logic [REG_ADDR_W-1:0] raddr2,
  input  logic [XLEN-1:0]       rdata1,
  input  logic [XLEN-1:0]       rdata2,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_waddr,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_op1,
  output logic [XLEN-1:0]       out_op2,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_rd_en,
  output logic [TAG_W-1:0]      out_tag,
  output logic [31:0]           stall_cnt
);

  logic      busy_rs1, busy_rs2, busy_rd;
  logic      clr1, clr2, clrd;
  logic      src1_live, src2_live, dst_live;
  logic      raw1, raw2, waw;
  logic      haz, slot_free, accept, stall_evt;
  haz_kind_e haz_kind;

  assign src1_live = in_rs1_en && (in_rs1 != '0);
  assign src2_live = in_rs2_en && (in_rs2 != '0);
  assign dst_live  = in_rd_en  && (in_rd  != '0);

  // A writeback landing this cycle releases the register: the file forwards its data.
  assign clr1 = (wb_we == WriteEnable) && (wb_waddr == in_rs1);
  assign clr2 = (wb_we == WriteEnable) && (wb_waddr == in_rs2);
  assign clrd = (wb_we == WriteEnable) && (wb_waddr == in_rd);

  assign raw1 = src1_live && busy_rs1 && !clr1;
  assign raw2 = src2_live && busy_rs2 && !clr2;
  assign waw  = dst_live  && busy_rd  && !clrd;

  always_comb begin
    haz_kind = HAZ_NONE;
    if (raw1 || raw2) begin
      haz_kind = HAZ_RAW;
    end else if (waw) begin
      haz_kind = HAZ_WAW;
    end
  end

  assign haz       = (haz_kind != HAZ_NONE);
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free && !haz && !flush;
  assign accept    = in_valid && in_ready;
  assign stall_evt = in_valid && slot_free && haz && !flush;

  assign re1    = (rst != RstEnable) && in_valid && (in_rs1_en == ReadEnable);
  assign re2    = (rst != RstEnable) && in_valid && (in_rs2_en == ReadEnable);
  assign raddr1 = in_rs1;
  assign raddr2 = in_rs2;

  of_scoreboard #(
    .ADDR_W (REG_ADDR_W)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en    (accept && in_rd_en),
    .set_addr  (in_rd),
    .kill_en   (flush && out_valid && out_rd_en),
    .kill_addr (out_rd),
    .clr_en    (wb_we == WriteEnable),
    .clr_addr  (wb_waddr),
    .rs1       (in_rs1),
    .rs2       (in_rs2),
    .rd        (in_rd),
    .busy_rs1  (busy_rs1),
    .busy_rs2  (busy_rs2),
    .busy_rd   (busy_rd)
  );

  // Data fields only move on accept, so they stay stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      out_valid <= 1'b0;
      out_op1   <= '0;
      out_op2   <= '0;
      out_rd    <= '0;
      out_rd_en <= 1'b0;
      out_tag   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_op1   <= src1_live ? rdata1 : '0;
      out_op2   <= src2_live ? rdata2 : '0;
      out_rd    <= in_rd;
      out_rd_en <= in_rd_en;
      out_tag   <= in_tag;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      stall_cnt <= '0;
    end else if (stall_evt) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a register-file model and an expected-output queue.
module tb_operand_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rs1_en, in_rs2_en, in_rd_en;
  logic [31:0] in_tag;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_op1, out_op2;
  logic [4:0]  out_rd;
  logic        out_rd_en;
  logic [31:0] out_tag;
  logic [31:0] stall_cnt;

  logic [31:0][31:0] rf;
  logic              rd1_force;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        rd_en;
    logic [31:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Register file with same-cycle write forwarding; port 1 can be overridden with junk.
  assign rdata1 = rd1_force ? 32'h0000_DEAD :
                  ((wb_we && wb_waddr == raddr1) ? wb_wdata : rf[raddr1]);
  assign rdata2 = (wb_we && wb_waddr == raddr2) ? wb_wdata : rf[raddr2];

  wire [31:0] busy = dut.u_sb.busy_q;

  operand_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_rs1_en (in_rs1_en),
    .in_rs2_en (in_rs2_en),
    .in_rd     (in_rd),
    .in_rd_en  (in_rd_en),
    .in_tag    (in_tag),
    .re1       (re1),
    .re2       (re2),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .rdata1    (rdata1),
    .rdata2    (rdata2),
    .wb_we     (wb_we),
    .wb_waddr  (wb_waddr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op1   (out_op1),
    .out_op2   (out_op2),
    .out_rd    (out_rd),
    .out_rd_en (out_rd_en),
    .out_tag   (out_tag),
    .stall_cnt (stall_cnt)
  );

  function automatic exp_t mk(input logic [31:0] op1, input logic [31:0] op2,
                              input logic [4:0] rd, input logic rd_en, input logic [31:0] tag);
    exp_t e;
    e.op1   = op1;
    e.op2   = op2;
    e.rd    = rd;
    e.rd_en = rd_en;
    e.tag   = tag;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic e1,
                       input logic [4:0] rs2, input logic e2,
                       input logic [4:0] rd, input logic ed, input logic [31:0] tag);
    in_valid  = v;
    in_rs1    = rs1;
    in_rs1_en = e1;
    in_rs2    = rs2;
    in_rs2_en = e2;
    in_rd     = rd;
    in_rd_en  = ed;
    in_tag    = tag;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    wb_we    = we;
    wb_waddr = a;
    wb_wdata = d;
  endtask

  // One clock with inputs already driven: check in_ready, queue the expected entry
  // when acceptance is expected, then compare the registered output after the edge.
  task automatic cycle(input logic exp_rdy, input exp_t e);
    logic take;
    exp_t x;
    #1;
    chk("in_ready", in_ready, exp_rdy);
    take = exp_rdy && in_valid;
    if (take) exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (wb_we && wb_waddr != 5'd0) rf[wb_waddr] = wb_wdata;
    if (take) begin
      x = exp_q.pop_front();
      chk("out_valid", out_valid, 1'b1);
      chk("out_op1",   out_op1,   x.op1);
      chk("out_op2",   out_op2,   x.op2);
      chk("out_rd",    out_rd,    x.rd);
      chk("out_rd_en", out_rd_en, x.rd_en);
      chk("out_tag",   out_tag,   x.tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of the sequence");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t none;
    none = mk(32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    rf        = '0;
    rf[1]     = 32'd5;
    rf[2]     = 32'd7;
    rf[5]     = 32'h55;
    rd1_force = 1'b0;
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    set_wb(1'b0, 5'd0, 32'd0);
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 32'd0);

    // reset state, read enables gated while in reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_re1",       re1,       1'b0);
    chk("rst_re2",       re2,       1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_busy",      busy,      32'd0);
    chk("rst_out_tag",   out_tag,   32'd0);
    rst = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0);

    // independent issue: add x3 = x1 + x2
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 32'h100);
    #1;
    chk("issue_re1",    re1,    1'b1);
    chk("issue_re2",    re2,    1'b1);
    chk("issue_raddr1", raddr1, 5'd1);
    chk("issue_raddr2", raddr2, 5'd2);
    cycle(1'b1, mk(32'd5, 32'd7, 5'd3, 1'b1, 32'h100));
    chk("busy3_set", busy[3], 1'b1);

    // RAW on x3: three stall cycles, released by the writeback cycle
    drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 32'h200);
    for (int i = 0; i < 3; i++) cycle(1'b0, none);
    chk("raw_stall_cnt", stall_cnt, 32'd3);
    chk("raw_drained",   out_valid, 1'b0);
    set_wb(1'b1, 5'd3, 32'd12);
    cycle(1'b1, mk(32'd12, 32'd0, 5'd6, 1'b1, 32'h200));
    chk("raw_busy3_clr",   busy[3],   1'b0);
    chk("raw_stall_final", stall_cnt, 32'd3);

    // x0 reads as zero despite junk rdata; rd=4 set collides with a writeback to x4
    rd1_force = 1'b1;
    set_wb(1'b1, 5'd4, 32'h44);
    drive(1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 32'h300);
    cycle(1'b1, mk(32'd0, 32'd5, 5'd4, 1'b1, 32'h300));
    chk("collide_busy4", busy[4], 1'b1);
    rd1_force = 1'b0;
    set_wb(1'b0, 5'd0, 32'd0);

    // backpressure: entry holds, next instruction waits, no stall counted
    out_ready = 1'b0;
    drive(1'b1, 5'd2, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 32'h400);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, none);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_out_op2",   out_op2,   32'd5);
      chk("bp_out_tag",   out_tag,   32'h300);
    end
    chk("bp_stall_cnt", stall_cnt, 32'd3);
    out_ready = 1'b1;
    cycle(1'b1, mk(32'd7, 32'd5, 5'd7, 1'b1, 32'h400));

    // WAW on x6, released by writeback; the new writer keeps x6 busy
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 32'h500);
    cycle(1'b0, none);
    chk("waw_stall_cnt", stall_cnt, 32'd4);
    set_wb(1'b1, 5'd6, 32'h66);
    cycle(1'b1, mk(32'd0, 32'd0, 5'd6, 1'b1, 32'h500));
    chk("waw_busy6", busy[6], 1'b1);

    // writeback to x0 is ignored
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0);
    set_wb(1'b1, 5'd0, 32'h99);
    cycle(1'b1, none);
    chk("x0_wb_busy", busy, 32'h0000_00D0);
    set_wb(1'b0, 5'd0, 32'd0);

    // flush kills the held rd=5 entry and its busy bit
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 32'h600);
    cycle(1'b1, mk(32'd0, 32'd0, 5'd5, 1'b1, 32'h600));
    chk("flush_busy5_pre", busy[5], 1'b1);
    out_ready = 1'b0;
    flush     = 1'b1;
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h700);
    cycle(1'b0, none);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_busy5",     busy[5],   1'b0);
    chk("flush_stall_cnt", stall_cnt, 32'd4);
    flush     = 1'b0;
    out_ready = 1'b1;
    cycle(1'b1, mk(32'h55, 32'd0, 5'd0, 1'b0, 32'h700));

    // retire x4, x6, x7 then build busy = {x5, x3}
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0);
    set_wb(1'b1, 5'd4, 32'h404);
    cycle(1'b1, none);
    set_wb(1'b1, 5'd6, 32'h606);
    cycle(1'b1, none);
    set_wb(1'b1, 5'd7, 32'h707);
    cycle(1'b1, none);
    chk("retire_busy", busy, 32'd0);
    set_wb(1'b0, 5'd0, 32'd0);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 32'h800);
    cycle(1'b1, mk(32'd0, 32'd0, 5'd3, 1'b1, 32'h800));
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 32'h900);
    cycle(1'b1, mk(32'd0, 32'd0, 5'd5, 1'b1, 32'h900));
    chk("pre_rst_busy", busy, 32'h0000_0028);

    // reset mid-backpressure with a stalled instruction waiting
    out_ready = 1'b0;
    rst       = 1'b1;
    drive(1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 32'hA00);
    #1;
    chk("midrst_re1", re1, 1'b0);
    chk("midrst_re2", re2, 1'b0);
    @(posedge clk);
    #1;
    chk("midrst_busy",      busy,      32'd0);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_stall_cnt", stall_cnt, 32'd0);
    chk("midrst_out_rd",    out_rd,    5'd0);
    chk("midrst_out_op1",   out_op1,   32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    cycle(1'b1, mk(32'd12, 32'h55, 5'd0, 1'b0, 32'hA00));
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Read-side client of the integer register file, sitting in the ID stage between the decoder and EX.
- Accepts decoded instructions over a valid/ready handshake and drives the register file read ports (re1/raddr1, re2/raddr2).
- Tracks pending destination registers in a 32-entry scoreboard and stalls on RAW/WAW hazards until the matching writeback.
- Registers the fetched operands into a one-entry output stage toward EX.

Parameters:
XLEN, 32, data word width
REG_ADDR_W, 5, register index width (32 registers)
TAG_W, 32, pass-through tag width (PC or decode bundle)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  decoded instruction present
in_ready  out  1  instruction accepted this cycle when in_valid=1
in_rs1 / in_rs2  in  REG_ADDR_W each  source indices
in_rs1_en / in_rs2_en  in  1 each  source used
in_rd  in  REG_ADDR_W  destination index
in_rd_en  in  1  destination written
in_tag  in  TAG_W  pass-through
re1 / re2  out  1 each  register file read enables
raddr1 / raddr2  out  REG_ADDR_W each  register file read addresses
rdata1 / rdata2  in  XLEN each  register file read data, same-cycle combinational
wb_we  in  1  writeback enable, same signal that drives the register file write port
wb_waddr  in  REG_ADDR_W  writeback address
flush  in  1  kill the output entry and the current input
out_valid  out  1  operands valid toward EX
out_ready  in  1  EX accepts
out_op1 / out_op2  out  XLEN each  operands
out_rd  out  REG_ADDR_W  destination index
out_rd_en  out  1  destination written
out_tag  out  TAG_W  pass-through tag
stall_cnt  out  32  hazard-stall cycle counter, saturating

Behaviour:
- Reset (synchronous): out_valid=0; all out_* data fields=0; busy[31:0]=0; stall_cnt=0.
- Read-port drive (combinational):
  - re1 = in_valid & in_rs1_en; raddr1 = in_rs1. re2 and raddr2 likewise.
  - During rst, re1=re2=0.
- The register file forwards same-cycle writeback data, so a source written this cycle reads the new value.
- Clear condition: clr(r) = wb_we & (wb_waddr==r).
- Hazard (combinational):
  - haz = (in_rs1_en & rs1≠0 & busy[rs1] & !clr(rs1)) | (same term for rs2) | (in_rd_en & rd≠0 & busy[rd] & !clr(rd)).
  - The last term is the WAW check.
- Handshake:
  - slot_free = !out_valid | out_ready.
  - in_ready = slot_free & !haz & !flush.
  - accept = in_valid & in_ready.
- On accept, captured into the output stage on the next clk edge (latency 1):
  - out_op1 = (in_rs1_en & in_rs1≠0) ? rdata1 : 0. out_op2 likewise.
  - out_rd, out_rd_en and out_tag are copied from the input.
  - out_valid=1.
  - Register index 0 always yields 0, independent of rdata.
- If out_ready & out_valid & !accept: out_valid=0.
- Output data fields hold their value while out_valid=1 & !out_ready (stable under backpressure).
- Scoreboard, per register r≠0, next-state priority:
  - (1) accept & in_rd_en & in_rd==r → busy=1. Set wins over a same-cycle clear, because the new writer is younger.
  - (2) flush & out_valid & out_rd_en & out_rd==r → busy=0.
  - (3) clr(r) → busy=0.
  - (4) otherwise hold.
  - busy[0] is constant 0.
- Flush:
  - Next edge: out_valid=0; the killed entry's busy bit is cleared (rule 2).
  - in_ready=0 during the flush cycle.
  - Instructions already accepted by EX are not affected.
- stall_cnt increments by 1 each cycle with in_valid & slot_free & haz & !flush. It saturates at 0xFFFF_FFFF.
- Writeback to x0 is ignored (busy[0] stays 0).
- A writeback for a register that is not busy is a no-op.
- rst asserted mid-stall or mid-backpressure discards the output entry and clears all busy bits on that edge.

Decomposition:
- Shared defines file: XLEN, REG_ADDR_W, ZeroWord, RstEnable, ReadEnable, WriteEnable constants. These are reused unchanged by this block.
- One sub-module: of_scoreboard.
  - Holds busy[31:0] and the set/clear priority.
  - Provides combinational busy lookups for rs1, rs2 and rd.
- Output stage and stall counter stay in operand_fetch.

Test Plan:
- Independent issue:
  - Stimulus: regs x1=5, x2=7; send add rs1=1, rs2=2, rd=3 with out_ready=1.
  - Response: re1=re2=1, raddr1=1, raddr2=2; next cycle out_valid=1, op1=5, op2=7, rd=3, busy[3]=1.
- RAW stall and release:
  - Stimulus: after the above, send rs1=3; hold wb_we=0 for 3 cycles, then wb_we=1, waddr=3, wdata=12.
  - Response: in_ready=0 for 3 cycles and stall_cnt=3; accepted in the writeback cycle; op1=12; busy[3]=0 afterwards.
- x0 and set/clear collision:
  - Stimulus: rs1=0 with rdata1 forced to 0xDEAD; separately, issue rd=4 in the same cycle that wb_waddr=4.
  - Response: op1=0; busy[4]=1 after the edge.
- Backpressure:
  - Stimulus: out_ready=0 for 4 cycles with a second instruction waiting.
  - Response: outputs stable, in_ready=0; the second instruction is accepted on the cycle out_ready=1.
- Flush:
  - Stimulus: output holds rd=5 (busy[5]=1) and flush=1.
  - Response: out_valid=0 and busy[5]=0 next cycle; a following rs1=5 issues without stall.
- Reset mid-operation:
  - Stimulus: rst=1 for one cycle while busy=0x0000_0028 and out_valid=1.
  - Response: busy=0, out_valid=0, stall_cnt=0, re1=re2=0 during reset.
